id_stage_param: RTL and testbench
=================================

Name: id_stage_param

Overview:
- Parametrised next-generation instruction-decode stage for the pipelined MIPS core. Sits between IF and EX.
- Contains its own register file, N-source operand forwarding, a multi-mode branch/jump resolver, and an ID/EX pipeline register with valid/ready handshake, flush and bubble insertion.
- Adds saturating stall and bubble performance counters.
- Control decoding stays in the existing control unit; its encoded control vector and branch mode arrive as inputs.

Parameters:
- XLEN, 32, register/operand data width (≥16).
- REG_AW, 5, register address width; register count is 2**REG_AW.
- NUM_FWD, 2, number of forwarding sources.
- CTRL_W, 12, width of the control vector carried to EX.
- CNT_W, 16, performance counter width.
- Derived: FSEL_W = clog2(NUM_FWD+1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- if_valid_i  in  1  IF presents an instruction
- if_ready_o  out  1  stage accepts the instruction this cycle
- instr_i  in  32  instruction word
- next_pc_i  in  32  PC+4 of instr_i
- wb_we_i / wb_addr_i / wb_data_i  in  1 / REG_AW / XLEN  register-file write port
- rs_fwd_sel_i, rt_fwd_sel_i  in  FSEL_W each  forwarding selects
- fwd_data_i  in  NUM_FWD*XLEN  forwarded values; source k occupies slice k
- hazard_i  in  1  load-use hazard from the hazard unit
- flush_i  in  1  kill the instruction in ID and in ID/EX
- ctrl_i  in  CTRL_W  control vector for instr_i
- br_mode_i  in  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 jump, 6-7 none
- id_rs_o, id_rt_o  out  REG_AW each  instr_i[25:21], instr_i[20:16] (low REG_AW bits)
- id_opcode_o  out  6  instr_i[31:26]
- br_taken_o  out  1  redirect IF (combinational)
- br_target_o  out  32  redirect address
- ex_valid_o  out  1  ID/EX holds a live instruction
- ex_ready_i  in  1  EX accepts
- ex_a_o, ex_b_o  out  XLEN each  operands
- ex_rs_o, ex_rt_o, ex_rd_o  out  REG_AW each  register numbers
- ex_opcode_o  out  6  opcode
- ex_imm_o  out  XLEN  sign-extended immediate
- ex_ctrl_o  out  CTRL_W  control vector
- stall_cnt_o, bubble_cnt_o  out  CNT_W each  performance counters

Behaviour:
- Reset (rst=0, asynchronous):
  - All register-file entries, all ex_* outputs, ex_valid_o and both counters clear to 0.
  - Consequently if_ready_o=1 after reset unless hazard_i=1.
- Register file:
  - Register 0 always reads 0; writes to it are ignored.
  - Write on clk edge when wb_we_i=1.
  - Same-cycle read of the address being written (nonzero) returns wb_data_i (write-first bypass).
- Forwarding mux, per operand:
  - sel 0 → register file.
  - sel k (1..NUM_FWD) → fwd_data_i slice k-1.
  - sel > NUM_FWD → 0.
- Immediate: instr_i[15:0] sign-extended to XLEN.
- Branch target: next_pc_i + (sext32(imm) << 2), wraps modulo 2^32.
- Jump target: {next_pc_i[31:28], instr_i[25:0], 2'b00}.
- br_target_o = jump target when br_mode_i=5, else branch target.
- advance = ex_ready_i | ~ex_valid_o.
- if_ready_o = flush_i | (advance & ~hazard_i).
- accept = if_valid_i & if_ready_o & ~flush_i.
- br_taken_o = accept & cond, where cond is evaluated on the forwarded A/B:
  - beq: A==B
  - bne: A!=B
  - blez: signed A ≤ 0
  - bgtz: signed A > 0
  - jump: 1
  - other modes: 0
- ID/EX register update, on posedge, priority order:
  1. flush_i: ex_valid_o←0, ex_ctrl_o←0. Other fields don't-care. Applies regardless of ex_ready_i. Instruction in ID is consumed and discarded.
  2. ~advance: all ex_* outputs and ex_valid_o hold, bit-stable.
  3. advance & hazard_i: bubble. ex_valid_o←0, ex_ctrl_o←0. instr_i is not consumed.
  4. advance & accept: load A, B, rs, rt, rd=instr_i[15:11], opcode, imm. If instr_i==0 (nop): ex_valid_o←0, ctrl←0. Otherwise ex_valid_o←1, ex_ctrl_o←ctrl_i.
  5. advance & ~if_valid_i: ex_valid_o←0, ctrl←0.
- Latency: one cycle from accept to ex_valid_o.
- stall_cnt_o: +1 each cycle with if_valid_i & ~if_ready_o.
- bubble_cnt_o: +1 each cycle case 3 applies.
- Both counters saturate at all-ones and do not increment during a flush_i cycle.
- Reset mid-operation: immediate clear. First accept is possible on the first clock edge after rst rises.

Test Plan:
1. Reset then write r5=0x1234 via WB; same cycle present instr rs=5, sel=0 → ex_a_o=0x1234 next cycle (bypass). Write to r0 → reads 0.
2. rs_fwd_sel=2, fwd slice1=0xDEADBEEF, NUM_FWD=2 → ex_a_o=0xDEADBEEF. sel=3 → 0.
3. beq A=B=7, next_pc=0x100, imm=0xFFFF → br_taken_o=1, br_target_o=0xFC. bgtz A=0x80000000 → not taken. Jump with next_pc=0xA0000004, index=0x10 → target 0xA0000040.
4. ex_valid_o=1, ex_ready_i=0 for 3 cycles with if_valid_i=1 → outputs stable, if_ready_o=0, stall_cnt_o=3.
5. hazard_i=1 one cycle with ex_ready_i=1 → bubble (ex_valid_o=0, ctrl=0), instr held, bubble_cnt_o=1. Next cycle instr enters with ex_valid_o=1.
6. flush_i together with ex_ready_i=0 and valid contents → ex_valid_o=0 next edge, br_taken_o=0. CNT_W=2 with 5 stall cycles → stall_cnt_o saturates at 3.

Source files
------------

// File: rtl/id_stage_param.sv
// Instruction-decode stage: register file, N-source forwarding, branch/jump resolution,
// ID/EX pipeline register with flush and bubble insertion, saturating stall/bubble counters.
module id_stage_param #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int CTRL_W  = 12,
  parameter int CNT_W   = 16,
  localparam int FSEL_W = $clog2(NUM_FWD + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid_i,
  output logic                     if_ready_o,
  input  logic [31:0]              instr_i,
  input  logic [31:0]              next_pc_i,
  input  logic                     wb_we_i,
  input  logic [REG_AW-1:0]        wb_addr_i,
  input  logic [XLEN-1:0]          wb_data_i,
  input  logic [FSEL_W-1:0]        rs_fwd_sel_i,
  input  logic [FSEL_W-1:0]        rt_fwd_sel_i,
  input  logic [NUM_FWD*XLEN-1:0]  fwd_data_i,
  input  logic                     hazard_i,
  input  logic                     flush_i,
  input  logic [CTRL_W-1:0]        ctrl_i,
  input  logic [2:0]               br_mode_i,
  output logic [REG_AW-1:0]        id_rs_o,
  output logic [REG_AW-1:0]        id_rt_o,
  output logic [5:0]               id_opcode_o,
  output logic                     br_taken_o,
  output logic [31:0]              br_target_o,
  output logic                     ex_valid_o,
  input  logic                     ex_ready_i,
  output logic [XLEN-1:0]          ex_a_o,
  output logic [XLEN-1:0]          ex_b_o,
  output logic [REG_AW-1:0]        ex_rs_o,
  output logic [REG_AW-1:0]        ex_rt_o,
  output logic [REG_AW-1:0]        ex_rd_o,
  output logic [5:0]               ex_opcode_o,
  output logic [XLEN-1:0]          ex_imm_o,
  output logic [CTRL_W-1:0]        ex_ctrl_o,
  output logic [CNT_W-1:0]         stall_cnt_o,
  output logic [CNT_W-1:0]         bubble_cnt_o
);

  // Handshake: IF hands over instr_i on a cycle where if_valid_i & if_ready_o & ~flush_i;
  // ID/EX hands over when ex_valid_o & ex_ready_i, and holds bit-stable otherwise.

  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_JUMP = 3'd5;

  logic [XLEN-1:0]   rf [2**REG_AW];
  logic [4:0]        rs_field, rt_field, rd_field;
  logic [REG_AW-1:0] rs_addr, rt_addr, rd_addr;
  logic [XLEN-1:0]   rs_rf, rt_rf, op_a, op_b, imm_x;
  logic [31:0]       imm32, branch_target, jump_target;
  logic              advance, accept, cond, is_nop;

  assign rs_field    = instr_i[25:21];
  assign rt_field    = instr_i[20:16];
  assign rd_field    = instr_i[15:11];
  assign rs_addr     = rs_field[REG_AW-1:0];
  assign rt_addr     = rt_field[REG_AW-1:0];
  assign rd_addr     = rd_field[REG_AW-1:0];
  assign id_rs_o     = rs_addr;
  assign id_rt_o     = rt_addr;
  assign id_opcode_o = instr_i[31:26];
  assign is_nop      = (instr_i == 32'd0);

  // Write-first read: a same-cycle write to the read address is visible immediately.
  assign rs_rf = (rs_addr == '0) ? '0 :
                 (wb_we_i && wb_addr_i == rs_addr) ? wb_data_i : rf[rs_addr];
  assign rt_rf = (rt_addr == '0) ? '0 :
                 (wb_we_i && wb_addr_i == rt_addr) ? wb_data_i : rf[rt_addr];

  function automatic logic [XLEN-1:0] fwd_mux(input logic [FSEL_W-1:0] sel,
                                              input logic [XLEN-1:0]   rf_val,
                                              input logic [NUM_FWD*XLEN-1:0] fwd);
    logic [XLEN-1:0] r;
    r = '0;
    if (sel == '0) r = rf_val;
    for (int k = 0; k < NUM_FWD; k++)
      if (sel == FSEL_W'(k + 1)) r = fwd[k*XLEN +: XLEN];
    return r;
  endfunction

  assign op_a = fwd_mux(rs_fwd_sel_i, rs_rf, fwd_data_i);
  assign op_b = fwd_mux(rt_fwd_sel_i, rt_rf, fwd_data_i);

  assign imm_x         = {{(XLEN-16){instr_i[15]}}, instr_i[15:0]};
  assign imm32         = {{16{instr_i[15]}}, instr_i[15:0]};
  assign branch_target = next_pc_i + {imm32[29:0], 2'b00};
  assign jump_target   = {next_pc_i[31:28], instr_i[25:0], 2'b00};
  assign br_target_o   = (br_mode_i == BR_JUMP) ? jump_target : branch_target;

  always_comb begin
    cond = 1'b0;
    case (br_mode_i)
      BR_BEQ:  cond = (op_a == op_b);
      BR_BNE:  cond = (op_a != op_b);
      BR_BLEZ: cond = op_a[XLEN-1] | (op_a == '0);
      BR_BGTZ: cond = ~op_a[XLEN-1] & (op_a != '0);
      BR_JUMP: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign advance    = ex_ready_i | ~ex_valid_o;
  // A flush always drains IF, so the stage reports ready during it.
  assign if_ready_o = flush_i | (advance & ~hazard_i);
  assign accept     = if_valid_i & if_ready_o & ~flush_i;
  assign br_taken_o = accept & cond;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**REG_AW; i++) rf[i] <= '0;
    end else if (wb_we_i && wb_addr_i != '0) begin
      rf[wb_addr_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_o  <= 1'b0;
      ex_a_o      <= '0;
      ex_b_o      <= '0;
      ex_rs_o     <= '0;
      ex_rt_o     <= '0;
      ex_rd_o     <= '0;
      ex_opcode_o <= '0;
      ex_imm_o    <= '0;
      ex_ctrl_o   <= '0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
      ex_ctrl_o  <= '0;
    end else if (advance) begin
      if (hazard_i || !if_valid_i) begin
        ex_valid_o <= 1'b0;
        ex_ctrl_o  <= '0;
      end else begin
        ex_a_o      <= op_a;
        ex_b_o      <= op_b;
        ex_rs_o     <= rs_addr;
        ex_rt_o     <= rt_addr;
        ex_rd_o     <= rd_addr;
        ex_opcode_o <= instr_i[31:26];
        ex_imm_o    <= imm_x;
        ex_valid_o  <= ~is_nop;
        ex_ctrl_o   <= is_nop ? '0 : ctrl_i;
      end
    end
  end

  logic stall_inc, bubble_inc;
  assign stall_inc  = ~flush_i & if_valid_i & ~if_ready_o;
  assign bubble_inc = ~flush_i & advance & hazard_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (stall_inc && stall_cnt_o != '1)   stall_cnt_o  <= stall_cnt_o + CNT_W'(1);
      if (bubble_inc && bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_stage_param.sv
// Bench for id_stage_param: directed scenarios plus randomized cycles checked against
// a cycle-level reference model of the decode stage.
module tb_id_stage_param;
  localparam int XLEN = 32, REG_AW = 5, NUM_FWD = 2, CTRL_W = 12, CNT_W = 3, FSEL_W = 2;
  localparam int NREG = 2**REG_AW;
  localparam int CNT_MAX = 2**CNT_W - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                    if_valid, if_ready, wb_we, hazard, flush, br_taken, ex_valid, ex_ready;
  logic [31:0]             instr, next_pc, br_target;
  logic [REG_AW-1:0]       wb_addr, id_rs, id_rt, ex_rs, ex_rt, ex_rd;
  logic [XLEN-1:0]         wb_data, ex_a, ex_b, ex_imm;
  logic [FSEL_W-1:0]       rs_sel, rt_sel;
  logic [XLEN-1:0]         fwd_w [NUM_FWD];
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic [CTRL_W-1:0]       ctrl, ex_ctrl;
  logic [2:0]              br_mode;
  logic [5:0]              id_opcode, ex_opcode;
  logic [CNT_W-1:0]        stall_cnt, bubble_cnt;

  always_comb begin
    fwd_data = '0;
    for (int k = 0; k < NUM_FWD; k++) fwd_data[k*XLEN +: XLEN] = fwd_w[k];
  end

  id_stage_param #(.XLEN(XLEN), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_ready_o(if_ready), .instr_i(instr),
    .next_pc_i(next_pc), .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .rs_fwd_sel_i(rs_sel), .rt_fwd_sel_i(rt_sel), .fwd_data_i(fwd_data), .hazard_i(hazard),
    .flush_i(flush), .ctrl_i(ctrl), .br_mode_i(br_mode), .id_rs_o(id_rs), .id_rt_o(id_rt),
    .id_opcode_o(id_opcode), .br_taken_o(br_taken), .br_target_o(br_target),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_a_o(ex_a), .ex_b_o(ex_b),
    .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd), .ex_opcode_o(ex_opcode),
    .ex_imm_o(ex_imm), .ex_ctrl_o(ex_ctrl), .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
  );

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   a, b, imm;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [5:0]        op;
    int                stall, bubble;
  } ex_t;

  ex_t             exp_q[$];
  ex_t             m_st;
  logic [XLEN-1:0] m_rf [NREG];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] m_read(input int r);
    if (r == 0) return '0;
    if (wb_we && int'(wb_addr) == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic logic [XLEN-1:0] m_operand(input int sel, input int r);
    if (sel == 0) return m_read(r);
    if (sel <= NUM_FWD) return fwd_w[sel-1];
    return '0;
  endfunction

  task automatic set_idle();
    if_valid = 0; hazard = 0; flush = 0; ex_ready = 1; wb_we = 0; wb_addr = '0; wb_data = '0;
    rs_sel = '0; rt_sel = '0; br_mode = '0; instr = '0; next_pc = '0; ctrl = '0;
    for (int k = 0; k < NUM_FWD; k++) fwd_w[k] = '0;
  endtask

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Inputs are already driven (at a negedge). Checks combinational outputs, advances the
  // model by one clock and checks the registered outputs at the following negedge.
  task automatic tick();
    logic [XLEN-1:0] a, b;
    logic adv, rdy, acc, cond;
    logic [31:0] tgt;
    int rs_n, rt_n;
    ex_t nx, e;
    #1;
    rs_n = int'(instr[25:21]);
    rt_n = int'(instr[20:16]);
    a = m_operand(int'(rs_sel), rs_n);
    b = m_operand(int'(rt_sel), rt_n);
    adv = ex_ready || !m_st.valid;
    rdy = flush || (adv && !hazard);
    acc = if_valid && rdy && !flush;
    case (br_mode)
      3'd1: cond = (a == b);
      3'd2: cond = (a != b);
      3'd3: cond = ($signed(a) <= 0);
      3'd4: cond = ($signed(a) > 0);
      3'd5: cond = 1'b1;
      default: cond = 1'b0;
    endcase
    if (br_mode == 3'd5) tgt = {next_pc[31:28], instr[25:0], 2'b00};
    else tgt = next_pc + 32'(int'($signed(instr[15:0])) * 4);
    check_eq("if_ready", if_ready, rdy);
    check_eq("br_taken", br_taken, acc && cond);
    check_eq("br_target", br_target, tgt);
    check_eq("id_rs", id_rs, rs_n);
    check_eq("id_rt", id_rt, rt_n);
    check_eq("id_opcode", id_opcode, instr[31:26]);

    nx = m_st;
    if (flush) begin
      nx.valid = 0; nx.ctrl = '0;
    end else if (adv && hazard) begin
      nx.valid = 0; nx.ctrl = '0;
    end else if (adv && if_valid) begin
      nx.a = a; nx.b = b; nx.rs = REG_AW'(rs_n); nx.rt = REG_AW'(rt_n);
      nx.rd = instr[15:11]; nx.op = instr[31:26];
      nx.imm = XLEN'(int'($signed(instr[15:0])));
      nx.valid = (instr != 0);
      nx.ctrl = (instr != 0) ? ctrl : '0;
    end else if (adv) begin
      nx.valid = 0; nx.ctrl = '0;
    end
    if (!flush && if_valid && !rdy) nx.stall = (m_st.stall < CNT_MAX) ? m_st.stall + 1 : CNT_MAX;
    if (!flush && adv && hazard) nx.bubble = (m_st.bubble < CNT_MAX) ? m_st.bubble + 1 : CNT_MAX;
    exp_q.push_back(nx);

    @(posedge clk);
    if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
    m_st = nx;
    @(negedge clk);
    e = exp_q.pop_front();
    check_eq("ex_valid", ex_valid, e.valid);
    check_eq("ex_ctrl", ex_ctrl, e.ctrl);
    check_eq("stall_cnt", stall_cnt, e.stall);
    check_eq("bubble_cnt", bubble_cnt, e.bubble);
    if (e.valid) begin
      check_eq("ex_a", ex_a, e.a);
      check_eq("ex_b", ex_b, e.b);
      check_eq("ex_rs", ex_rs, e.rs);
      check_eq("ex_rt", ex_rt, e.rt);
      check_eq("ex_rd", ex_rd, e.rd);
      check_eq("ex_opcode", ex_opcode, e.op);
      check_eq("ex_imm", ex_imm, e.imm);
    end
  endtask

  // Called at a negedge; reset is asserted asynchronously and must clear outputs at once.
  task automatic do_reset();
    set_idle();
    rst = 0;
    #1;
    check_eq("rst_ex_valid", ex_valid, 0);
    check_eq("rst_ex_ctrl", ex_ctrl, 0);
    check_eq("rst_ex_a", ex_a, 0);
    check_eq("rst_ex_b", ex_b, 0);
    check_eq("rst_stall", stall_cnt, 0);
    check_eq("rst_bubble", bubble_cnt, 0);
    check_eq("rst_if_ready", if_ready, 1);
    m_st = '0;
    for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    exp_q.delete();
    @(negedge clk);
    rst = 1;
  endtask

  task automatic load_one(input logic [XLEN-1:0] a_val);
    ex_ready = 1; if_valid = 1; rs_sel = 2'd1; fwd_w[0] = a_val;
    instr = mk_i(6'h08, 5'd3, 5'd4, 16'h0010); ctrl = 12'h3C3;
    tick();
  endtask

  initial begin
    set_idle();
    @(negedge clk);

    // Write-first bypass and r0
    do_reset();
    wb_we = 1; wb_addr = 5; wb_data = 32'h1234;
    if_valid = 1; instr = mk_i(6'h08, 5'd5, 5'd0, 16'h0001); ctrl = 12'h5A5;
    tick();
    check_eq("bypass_a", ex_a, 32'h1234);
    check_eq("bypass_valid", ex_valid, 1);
    wb_addr = 0; wb_data = 32'hFFFF_FFFF; instr = mk_i(6'h08, 5'd0, 5'd5, 16'h0001);
    tick();
    check_eq("r0_a", ex_a, 0);
    check_eq("r5_b", ex_b, 32'h1234);

    // Forwarding selects
    wb_we = 0; rs_sel = 2; fwd_w[1] = 32'hDEAD_BEEF;
    tick();
    check_eq("fwd2_a", ex_a, 32'hDEAD_BEEF);
    rs_sel = 3;
    tick();
    check_eq("fwd_oob_a", ex_a, 0);

    // Branch resolution
    rs_sel = 1; rt_sel = 1; fwd_w[0] = 7; next_pc = 32'h100; br_mode = 3'd1;
    instr = mk_i(6'h04, 5'd1, 5'd2, 16'hFFFF);
    #1;
    check_eq("beq_taken", br_taken, 1);
    check_eq("beq_target", br_target, 32'hFC);
    tick();
    fwd_w[0] = 32'h8000_0000; br_mode = 3'd4; instr = mk_i(6'h07, 5'd1, 5'd0, 16'h0004);
    #1;
    check_eq("bgtz_neg", br_taken, 0);
    tick();
    next_pc = 32'hA000_0004; br_mode = 3'd5; instr = {6'h02, 26'h10};
    #1;
    check_eq("jump_taken", br_taken, 1);
    check_eq("jump_target", br_target, 32'hA000_0040);
    tick();

    // Backpressure stalls
    do_reset();
    load_one(32'h0BAD_F00D);
    ex_ready = 0; if_valid = 1; fwd_w[0] = 32'h1111_1111; instr = mk_i(6'h09, 5'd1, 5'd1, 16'h7);
    #1;
    check_eq("stall_if_ready", if_ready, 0);
    for (int i = 0; i < 3; i++) begin
      fwd_w[0] = $urandom;
      tick();
    end
    check_eq("stall_cnt3", stall_cnt, 3);
    check_eq("stall_hold_a", ex_a, 32'h0BAD_F00D);

    // Bubble insertion
    do_reset();
    hazard = 1; ex_ready = 1; if_valid = 1; instr = mk_i(6'h08, 5'd2, 5'd2, 16'h5); ctrl = 12'h0F0;
    tick();
    check_eq("bubble_valid", ex_valid, 0);
    check_eq("bubble_cnt1", bubble_cnt, 1);
    hazard = 0;
    tick();
    check_eq("after_bubble_valid", ex_valid, 1);

    // Flush against backpressure, then counter saturation
    do_reset();
    load_one(32'h42);
    ex_ready = 0; flush = 1; br_mode = 3'd5;
    #1;
    check_eq("flush_br_taken", br_taken, 0);
    tick();
    check_eq("flush_valid", ex_valid, 0);
    flush = 0; br_mode = 0;
    load_one(32'h43);
    ex_ready = 0;
    for (int i = 0; i < 10; i++) tick();
    check_eq("stall_sat", stall_cnt, CNT_MAX);

    // Randomized traffic with one asynchronous reset in the middle
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc == 700) do_reset();
      if_valid = ($urandom_range(0, 9) < 8);
      hazard   = ($urandom_range(0, 99) < 15);
      flush    = ($urandom_range(0, 99) < 8);
      ex_ready = ($urandom_range(0, 9) < 7);
      wb_we    = $urandom_range(0, 1);
      wb_addr  = REG_AW'($urandom_range(0, 7));
      wb_data  = $urandom;
      rs_sel   = FSEL_W'($urandom_range(0, 3));
      rt_sel   = FSEL_W'($urandom_range(0, 3));
      for (int k = 0; k < NUM_FWD; k++)
        fwd_w[k] = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 2)) : $urandom;
      br_mode  = 3'($urandom_range(0, 7));
      next_pc  = $urandom;
      ctrl     = CTRL_W'($urandom_range(0, 4095));
      if ($urandom_range(0, 15) == 0) instr = '0;
      else begin
        instr = $urandom;
        instr[25:21] = 5'($urandom_range(0, 7));
        instr[20:16] = 5'($urandom_range(0, 7));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
